// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer (main + skid) with fully registered valid/ready decode.
// Optional synchronous flush port when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid_buffer #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic            flush,
`endif
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [SIZE-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [SIZE-1:0] m_data
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t          state_p0, state_nxt;
  logic [SIZE-1:0] main_p0, main_nxt;
  logic [SIZE-1:0] skid_p0, skid_nxt;
  logic            flush_w;
  logic            up, dn;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Handshake outputs depend on registered state only (plus flush gating).
  assign m_valid = (state_p0 != EMPTY);
  assign m_data  = main_p0;
  assign s_ready = (state_p0 != FULL) && !flush_w;

  assign up = s_valid && s_ready;
  assign dn = m_valid && m_ready;

  always_comb begin
    state_nxt = state_p0;
    main_nxt  = main_p0;
    skid_nxt  = skid_p0;
    case (state_p0)
      EMPTY: begin
        if (up) begin
          state_nxt = BUSY;
          main_nxt  = s_data;
        end
      end
      BUSY: begin
        if (up && dn) begin
          main_nxt = s_data;
        end else if (dn) begin
          state_nxt = EMPTY;
        end else if (up) begin
          state_nxt = FULL;
          skid_nxt  = s_data;
        end
      end
      FULL: begin
        if (dn) begin
          state_nxt = BUSY;
          main_nxt  = skid_p0;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush overrides everything; a coincident downstream pop counts as done.
    if (flush_w) begin
      state_nxt = EMPTY;
      main_nxt  = '0;
      skid_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= EMPTY;
      main_p0  <= '0;
      skid_p0  <= '0;
    end else begin
      state_p0 <= state_nxt;
      main_p0  <= main_nxt;
      skid_p0  <= skid_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and randomized self-checking bench for pipe_skid_buffer.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
`ifdef PIPE_SKID_FLUSH_EN
  logic        flush;
`endif

  int checks;
  int failures;

  pipe_skid_buffer #(.SIZE(32)) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef PIPE_SKID_FLUSH_EN
    .flush   (flush),
`endif
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] cur, hold_d, exp_d;
  logic        hold;
  int          sent, rcvd, cyc;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    s_valid  = 1'b1;
    s_data   = 32'h55;
    m_ready  = 1'b1;
`ifdef PIPE_SKID_FLUSH_EN
    flush    = 1'b0;
`endif
    #1;
    chk("rst_mvalid", m_valid, 0);
    chk("rst_mdata", m_data, 0);
    chk("rst_sready", s_ready, 1);
    step(); step();
    chk("rst_hold_mvalid", m_valid, 0);
    chk("rst_hold_mdata", m_data, 0);
    rst     = 1'b1;
    s_valid = 1'b0;
    step();
    chk("post_rst_mvalid", m_valid, 0);

    // single transfer
    s_valid = 1'b1; s_data = 32'h11; m_ready = 1'b1;
    chk("single_sready_pre", s_ready, 1);
    step();
    s_valid = 1'b0;
    chk("single_mvalid", m_valid, 1);
    chk("single_mdata", m_data, 32'h11);
    chk("single_sready", s_ready, 1);
    step();
    chk("single_drain", m_valid, 0);

    // back-to-back stream, no bubbles
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = i;
      step();
      chk("stream_mvalid", m_valid, 1);
      chk("stream_mdata", m_data, i);
      chk("stream_sready", s_ready, 1);
    end
    s_valid = 1'b0;
    step();
    chk("stream_drain", m_valid, 0);

    // fill to FULL with downstream stalled
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hA;
    step();
    s_data = 32'hB;
    step();
    s_valid = 1'b0;
    chk("full_sready", s_ready, 0);
    chk("full_mdata", m_data, 32'hA);
    step();
    chk("full_hold_mvalid", m_valid, 1);
    chk("full_hold_mdata", m_data, 32'hA);
    m_ready = 1'b1;
    step();
    chk("pop1_mdata", m_data, 32'hB);
    chk("pop1_mvalid", m_valid, 1);
    chk("pop1_sready", s_ready, 1);
    step();
    chk("pop2_mvalid", m_valid, 0);

    // reset while FULL drops both entries at once
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'hC;
    step();
    s_data = 32'hD;
    step();
    s_valid = 1'b0;
    chk("rfull_sready", s_ready, 0);
    rst = 1'b0;
    #1;
    chk("rmid_mvalid", m_valid, 0);
    chk("rmid_mdata", m_data, 0);
    chk("rmid_sready", s_ready, 1);
    step();
    rst = 1'b1;
    m_ready = 1'b1;
    step();
    chk("rmid_after_mvalid", m_valid, 0);
    s_valid = 1'b1; s_data = 32'h33;
    step();
    s_valid = 1'b0;
    chk("rmid_new_mdata", m_data, 32'h33);
    step();
    chk("rmid_new_drain", m_valid, 0);

`ifdef PIPE_SKID_FLUSH_EN
    // flush in BUSY gates s_ready combinationally
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 32'h21;
    step();
    flush = 1'b1; s_data = 32'h2E;
    #1;
    chk("flush_busy_sready", s_ready, 0);
    step();
    flush = 1'b0; s_valid = 1'b0;
    chk("flush_busy_mvalid", m_valid, 0);
    // flush in FULL with upstream offering 0xE
    s_valid = 1'b1; s_data = 32'h22;
    step();
    s_data = 32'h23;
    step();
    flush = 1'b1; s_data = 32'hE;
    #1;
    chk("flush_full_sready", s_ready, 0);
    step();
    flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    chk("flush_full_mvalid", m_valid, 0);
    chk("flush_full_mdata", m_data, 0);
    step();
    chk("flush_no_e", m_valid, 0);
`endif

    // randomized traffic against a queue model
    s_valid = 1'b0; m_ready = 1'b0;
    step();
    sent = 0; rcvd = 0; cyc = 0; hold = 1'b0; hold_d = '0;
    cur  = $urandom;
    while (rcvd < 1000 && cyc < 20000) begin
      s_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      s_data  = cur;
      m_ready = (rcvd < 1000) && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (hold) begin
        chk("rand_hold_v", m_valid, 1);
        chk("rand_hold_d", m_data, hold_d);
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        sent++;
        cur = $urandom;
      end
      if (m_valid && m_ready) begin
        chk("rand_q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_d = q.pop_front();
          chk("rand_data", m_data, exp_d);
        end
        rcvd++;
      end
      hold   = m_valid && !m_ready;
      hold_d = m_data;
      step();
      cyc++;
    end
    s_valid = 1'b0; m_ready = 1'b0;
    chk("rand_count", rcvd, 1000);
    chk("rand_q_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_buffer.md
PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The block SHALL have one parameter: SIZE, default 32, payload width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port s_valid, input, 1 bit: upstream payload valid.
REQ-005 The block SHALL have port s_ready, output, 1 bit: block can accept upstream payload.
REQ-006 The block SHALL have port s_data, input, SIZE bits: upstream payload.
REQ-007 The block SHALL have port m_valid, output, 1 bit: downstream payload valid.
REQ-008 The block SHALL have port m_ready, input, 1 bit: downstream accepts payload.
REQ-009 The block SHALL have port m_data, output, SIZE bits: downstream payload.
REQ-010 The block SHALL have port flush, input, 1 bit, present only when PIPE_SKID_FLUSH_EN is defined: synchronous discard of all held payloads.

Function
REQ-011 The block SHALL complete an upstream transfer on a rising edge with s_valid=1 and s_ready=1, and a downstream transfer on a rising edge with m_valid=1 and m_ready=1.
REQ-012 The block SHALL hold two entries, main and skid, tracked by state EMPTY (none), BUSY (main only) or FULL (main and skid).
REQ-013 The block SHALL drive m_valid=1 in BUSY and FULL, m_data=main entry, and s_ready=1 in EMPTY and BUSY, both decoded from registered state only, with no combinational path from m_ready to s_ready.
REQ-014 The block SHALL move EMPTY->BUSY on upstream transfer, loading main.
REQ-015 The block SHALL, in BUSY, stay BUSY on simultaneous upstream and downstream transfer (main reloaded), go EMPTY on downstream only, and go FULL on upstream only (payload into skid).
REQ-016 The block SHALL, in FULL, move skid into main and go BUSY on downstream transfer; no upstream transfer occurs in FULL.
REQ-017 The block SHALL deliver payloads in acceptance order, unaltered, with none lost or duplicated.
REQ-018 The block SHALL give 1-cycle latency: a payload accepted at edge N into EMPTY appears on m_data with m_valid=1 after edge N.
REQ-019 The block SHALL sustain one transfer per cycle while m_ready is held 1.
REQ-020 The block SHALL hold m_valid and m_data stable while m_valid=1 and m_ready=0.

Reset
REQ-021 The block SHALL, while rst=0, force state EMPTY, main and skid to 0, m_valid=0, m_data=0 and s_ready=1.
REQ-022 The block SHALL accept no upstream transfer while rst=0; upstream payloads presented during reset are discarded.
REQ-023 The block SHALL, on rst asserted mid-operation, drop all held payloads immediately and restart from EMPTY on the first edge after release.

Configuration
REQ-024 The block SHALL, when PIPE_SKID_FLUSH_EN is defined, provide flush: with flush=1 at an edge, the next state is EMPTY and both entries are 0, regardless of other inputs.
REQ-025 The block SHALL, with PIPE_SKID_FLUSH_EN defined and flush=1, force s_ready=0 combinationally so no upstream transfer occurs in the flush cycle.
REQ-026 The block SHALL treat a downstream transfer coinciding with flush=1 as completed; no payload is re-presented after flush.
REQ-027 The block SHALL, without PIPE_SKID_FLUSH_EN, have no flush port and behave as REQ-011..REQ-023 only.

Verification
REQ-028 The bench SHALL cover reset then s_valid=1, s_data=0x11, m_ready=1 for one cycle -> m_valid=1, m_data=0x11 on next cycle; s_ready stays 1.
REQ-029 The bench SHALL cover a stream of 0x1..0x8 on consecutive cycles with m_ready=1 -> outputs 0x1..0x8 on consecutive cycles, no bubbles.
REQ-030 The bench SHALL cover pushing 0xA, 0xB with m_ready=0 -> state FULL, s_ready=0, m_data=0xA held; then m_ready=1 -> outputs 0xA then 0xB, s_ready=1 after the first pop.
REQ-031 The bench SHALL cover random s_valid and m_ready (50%) over 1000 payloads -> output sequence equals input sequence, and m_data never changes while m_valid=1 and m_ready=0.
REQ-032 The bench SHALL cover rst=0 asserted in FULL holding 0xC, 0xD -> m_valid=0, m_data=0, s_ready=1 immediately; after release, 0xC/0xD never appear.
REQ-033 The bench SHALL cover, with PIPE_SKID_FLUSH_EN, flush=1 for one cycle in FULL while s_valid=1, s_data=0xE -> s_ready=0 that cycle, m_valid=0 after the edge, and 0xE is never output.
